// File: rtl/fastserial_ctrl.sv
// fastserial_ctrl: Wishbone slave for the FTDI fast opto-isolated serial link.
// Generates FSCLK, serializes TX FIFO bytes onto FSDI and deserializes FSDO frames into an RX FIFO.
//
// TX / RX state machines (same two-state encoding):
//   state | meaning
//   IDLE  | TX: waiting for a fall with data queued and cts_s high; RX: waiting for a 0 start sample
//   SHIFT | frame in flight; a down-counter holds the number of bits still to go

module fastserial_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       wb_clk,
  input  logic       wb_rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] head,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

module fastserial_ctrl #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [3:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        o_irq,
  input  logic        i_fsdo,
  input  logic        i_fscts,
  output logic        o_fsclk,
  output logic        o_fsdi
);
  localparam int CW = $clog2(CLK_DIV);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic          ack_q, bus_rd, bus_wr;
  logic [1:0]    reg_sel;
  logic          en, chan, rxie, rxovr, txdrop;
  logic          cts_m, cts_s;
  logic [CW-1:0] div_cnt;
  logic          fsclk_q, tick, rise, fall;
  state_t        tx_state, tx_next, rx_state, rx_next;
  logic          tx_load, tx_done, fsdi_q, tx_busy;
  logic [8:0]    tx_sr;
  logic [3:0]    tx_left, rx_left;
  logic [7:0]    rx_sr;
  logic          rx_push;
  logic          tx_push, tx_empty, tx_full, rx_pop, rx_empty, rx_full;
  logic [7:0]    tx_head, rx_head;
  logic [31:0]   rdata;
  logic          unused_bits;

  assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0], wb_dat_i[31:10]};

  assign reg_sel = wb_adr_i[3:2];
  assign bus_rd  = ack_q && !wb_we_i;
  assign bus_wr  = ack_q && wb_we_i;
  assign tx_push = bus_wr && (reg_sel == 2'd0);
  assign rx_pop  = bus_rd && (reg_sel == 2'd0);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q  <= 1'b0;
      en     <= 1'b0;
      chan   <= 1'b0;
      rxie   <= 1'b0;
      rxovr  <= 1'b0;
      txdrop <= 1'b0;
      cts_m  <= 1'b0;
      cts_s  <= 1'b0;
    end else begin
      ack_q <= wb_cyc_i && wb_stb_i && !ack_q;
      cts_m <= i_fscts;
      cts_s <= cts_m;
      if (bus_wr && reg_sel == 2'd2) {rxie, chan, en} <= wb_dat_i[2:0];
      // a new overflow/drop in the same cycle as a clear wins, so no event is lost
      if (bus_wr && reg_sel == 2'd1 && wb_dat_i[8]) rxovr <= 1'b0;
      if (rx_push && rx_full) rxovr <= 1'b1;
      if (bus_wr && reg_sel == 2'd1 && wb_dat_i[9]) txdrop <= 1'b0;
      if (tx_push && tx_full) txdrop <= 1'b1;
    end
  end

  assign tick = en && (div_cnt == '0);
  assign rise = tick && !fsclk_q;
  assign fall = tick && fsclk_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      div_cnt <= CW'(CLK_DIV - 1);
      fsclk_q <= 1'b0;
    end else if (!en) begin
      div_cnt <= CW'(CLK_DIV - 1);
      fsclk_q <= 1'b0;
    end else if (tick) begin
      div_cnt <= CW'(CLK_DIV - 1);
      fsclk_q <= !fsclk_q;
    end else begin
      div_cnt <= div_cnt - CW'(1);
    end
  end

  always_comb begin
    tx_next = tx_state;
    tx_load = 1'b0;
    tx_done = 1'b0;
    if (fall) begin
      if (tx_state == IDLE) begin
        if (!tx_empty && cts_s) begin
          tx_load = 1'b1;
          tx_next = SHIFT;
        end
      end else if (tx_left == '0) begin
        tx_done = 1'b1;
        tx_next = IDLE;
      end
    end
  end

  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    if (rise) begin
      if (rx_state == IDLE) begin
        if (!i_fsdo) rx_next = SHIFT;
      end else if (rx_left == '0) begin
        rx_push = 1'b1;
        rx_next = IDLE;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      tx_state <= IDLE;
      rx_state <= IDLE;
    end else if (!en) begin
      tx_state <= IDLE;
      rx_state <= IDLE;
    end else begin
      tx_state <= tx_next;
      rx_state <= rx_next;
    end
  end

  // start bit goes out in the load cycle; tx_sr holds d0..d7 and chan still to send
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      fsdi_q  <= 1'b1;
      tx_sr   <= '0;
      tx_left <= '0;
    end else if (!en) begin
      fsdi_q  <= 1'b1;
      tx_left <= '0;
    end else if (tx_load) begin
      fsdi_q  <= 1'b0;
      tx_sr   <= {chan, tx_head};
      tx_left <= 4'd9;
    end else if (fall && tx_state == SHIFT) begin
      if (tx_done) begin
        fsdi_q <= 1'b1;
      end else begin
        fsdi_q  <= tx_sr[0];
        tx_sr   <= {1'b0, tx_sr[8:1]};
        tx_left <= tx_left - 4'd1;
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_sr   <= '0;
      rx_left <= '0;
    end else if (!en) begin
      rx_left <= '0;
    end else if (rise) begin
      if (rx_state == IDLE) begin
        rx_left <= 4'd8;
      end else if (rx_left != '0) begin
        rx_sr   <= {i_fsdo, rx_sr[7:1]};
        rx_left <= rx_left - 4'd1;
      end
    end
  end

  fastserial_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .push     (tx_push),
    .pop      (tx_load),
    .din      (wb_dat_i[7:0]),
    .head     (tx_head),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  fastserial_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .push     (rx_push),
    .pop      (rx_pop),
    .din      (rx_sr),
    .head     (rx_head),
    .empty    (rx_empty),
    .full     (rx_full)
  );

  assign tx_busy = (tx_state == SHIFT);

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0:    rdata = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
      2'd1:    rdata = {22'd0, txdrop, rxovr, 2'd0, tx_busy, cts_s,
                        rx_full, rx_empty, tx_empty, tx_full};
      2'd2:    rdata = {29'd0, rxie, chan, en};
      default: rdata = '0;
    endcase
  end

  assign wb_dat_o = ack_q ? rdata : '0;
  assign wb_ack_o = ack_q;
  assign o_irq    = rxie && !rx_empty;
  // gate combinationally so disabling the link idles the pins in the same cycle en drops
  assign o_fsclk  = en && fsclk_q;
  assign o_fsdi   = !en || fsdi_q;
endmodule

// File: tb/tb_fastserial_ctrl.sv
// Scoreboard bench for fastserial_ctrl: bus reads and TX frames are checked by monitors
// against expectations queued when the stimulus is issued.
module tb_fastserial_ctrl;
  localparam int CLK_DIV = 2;
  localparam int DEPTH   = 4;

  logic        wb_clk   = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic [3:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, o_irq, o_fsclk, o_fsdi;
  logic        i_fsdo  = 1'b1;
  logic        i_fscts = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  logic [9:0]  tx_q[$];
  bit          en_shadow   = 1'b0;
  bit          chan_shadow = 1'b0;

  bit          mon_busy   = 1'b0;
  int          mon_idx    = 0;
  logic [9:0]  mon_frame  = '0;
  logic [9:0]  cur_exp    = '0;
  logic        prev_clk   = 1'b0;
  bit          fall_seen  = 1'b0;
  int          cyc_cnt    = 0;
  int          idle_falls = 0;
  int          last_gap   = 0;

  fastserial_ctrl #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .wb_clk   (wb_clk),
    .wb_rst_n (wb_rst_n),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .o_irq    (o_irq),
    .i_fsdo   (i_fsdo),
    .i_fscts  (i_fscts),
    .o_fsclk  (o_fsclk),
    .o_fsdi   (o_fsdi)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // bus read monitor
  always @(negedge wb_clk) begin
    if (wb_ack_o && !wb_cyc_i) begin
      checks++; errors++;
      $display("FAIL idle_ack: ack seen with no cycle in progress");
    end else if (wb_ack_o && !wb_we_i) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_read: data 0x%08h with nothing queued", wb_dat_o);
      end else begin
        chk("bus_read", wb_dat_o, rd_q.pop_front());
      end
    end
  end

  // TX frame monitor: assembles FSDI at each fall, checks frame, stop level and FSCLK period
  always @(negedge wb_clk) begin
    if (!wb_rst_n || !en_shadow) begin
      mon_busy  = 1'b0;
      fall_seen = 1'b0;
      cyc_cnt   = 0;
      prev_clk  = o_fsclk;
    end else begin
      cyc_cnt++;
      if (prev_clk && !o_fsclk) begin
        if (fall_seen) chk("fsclk_period", 32'(cyc_cnt), 32'(2*CLK_DIV));
        fall_seen = 1'b1;
        cyc_cnt   = 0;
        if (mon_busy) begin
          if (mon_idx < 10) begin
            mon_frame[mon_idx] = o_fsdi;
            mon_idx++;
          end else begin
            chk("tx_stop", 32'(o_fsdi), 32'd1);
            chk("tx_frame", 32'(mon_frame), 32'(cur_exp));
            mon_busy   = 1'b0;
            idle_falls = 0;
          end
        end else if (!o_fsdi) begin
          if (tx_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: start bit with no frame queued");
          end else begin
            cur_exp      = tx_q.pop_front();
            mon_frame    = '0;
            mon_busy     = 1'b1;
            mon_idx      = 1;
            last_gap     = idle_falls;
          end
        end else begin
          idle_falls++;
        end
      end
      prev_clk = o_fsclk;
    end
  end

  task automatic bus(input logic [3:0] adr, input logic we, input logic [31:0] dat);
    int n;
    @(negedge wb_clk);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    n = 0;
    do begin
      @(negedge wb_clk);
      n++;
    end while (!wb_ack_o && n < 10);
    if (!wb_ack_o) begin
      checks++; errors++;
      $display("FAIL bus_ack: no ack within 10 cycles, adr 0x%0h", adr);
    end
    @(posedge wb_clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
    bus(adr, 1'b1, dat);
  endtask

  task automatic rd(input logic [3:0] adr, input logic [31:0] exp);
    rd_q.push_back(exp);
    bus(adr, 1'b0, 32'd0);
  endtask

  task automatic set_ctrl(input logic [2:0] v);
    wr(4'h8, {29'd0, v});
    en_shadow   = v[0];
    chan_shadow = v[1];
  endtask

  task automatic send_tx(input logic [7:0] b);
    tx_q.push_back({chan_shadow, b, 1'b0});
    wr(4'h0, {24'd0, b});
  endtask

  task automatic wait_edge(input logic want);
    logic p;
    p = o_fsclk;
    for (int n = 0; n < 100; n++) begin
      @(negedge wb_clk);
      if (p != want && o_fsclk == want) return;
      p = o_fsclk;
    end
    checks++; errors++;
    $display("FAIL fsclk_edge: no transition to %0b within 100 cycles", want);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic src, input bit chk_irq);
    logic [9:0] bits;
    bits = {src, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      wait_edge(1'b0);
      i_fsdo = bits[i];
    end
    wait_edge(1'b1);
    if (chk_irq) chk("rx_irq_latency", 32'(o_irq), 32'd1);
    wait_edge(1'b0);
    i_fsdo = 1'b1;
  endtask

  task automatic wait_tx_done();
    int n;
    n = 0;
    while ((tx_q.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge wb_clk);
      n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL tx_done: %0d frames still pending after 3000 cycles", tx_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // reset state
    repeat (3) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    chk("rst_fsdi", 32'(o_fsdi), 32'd1);
    chk("rst_fsclk", 32'(o_fsclk), 32'd0);
    chk("rst_irq", 32'(o_irq), 32'd0);
    chk("rst_ack", 32'(wb_ack_o), 32'd0);
    chk("rst_dat", wb_dat_o, 32'd0);
    rd(4'h4, 32'h0000_0006);
    rd(4'h8, 32'h0000_0000);

    // single frame 0xA5, chan 0
    i_fscts = 1'b1;
    repeat (3) @(negedge wb_clk);
    set_ctrl(3'b001);
    send_tx(8'hA5);
    wait_edge(1'b0);
    chk("tx_latency", 32'(o_fsdi), 32'd0);
    wait_tx_done();
    rd(4'h4, 32'h0000_0016);

    // cts low holds frames; raising it releases them back to back
    i_fscts = 1'b0;
    repeat (3) @(negedge wb_clk);
    send_tx(8'h11);
    send_tx(8'h22);
    cnt = 0;
    repeat (40) begin
      @(negedge wb_clk);
      if (!o_fsdi) cnt++;
    end
    chk("cts_hold", 32'(cnt), 32'd0);
    rd(4'h4, 32'h0000_0004);
    i_fscts = 1'b1;
    wait_tx_done();
    chk("b2b_gap", 32'(last_gap), 32'd0);

    // receive 0x3C, source bit 1, with interrupt enabled
    set_ctrl(3'b101);
    rd(4'h8, 32'h0000_0005);
    send_rx(8'h3C, 1'b1, 1'b1);
    rd(4'h0, 32'h0000_013C);
    chk("irq_after_pop", 32'(o_irq), 32'd0);
    rd(4'h0, 32'h0000_0000);
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, 32'h0000_0000);

    // TX drop and RX overflow
    i_fscts = 1'b0;
    repeat (3) @(negedge wb_clk);
    for (int i = 1; i <= 6; i++) begin
      if (i <= DEPTH) send_tx(8'(i));
      else wr(4'h0, 32'(i));
    end
    rd(4'h4, 32'h0000_0205);
    for (int i = 0; i < 5; i++) send_rx(8'(8'h10 + i), 1'b0, 1'b0);
    rd(4'h4, 32'h0000_0309);
    chk("irq_pending", 32'(o_irq), 32'd1);
    for (int i = 0; i < 4; i++) rd(4'h0, 32'h100 | 32'(8'h10 + i));
    wr(4'h4, 32'h0000_0300);
    rd(4'h4, 32'h0000_0005);
    i_fscts = 1'b1;
    wait_tx_done();
    rd(4'h4, 32'h0000_0016);

    // disable mid-frame: frame lost, queued bytes retained
    set_ctrl(3'b011);
    send_tx(8'h5A);
    send_tx(8'h6B);
    send_tx(8'h7C);
    repeat (4) wait_edge(1'b0);
    set_ctrl(3'b010);
    chk("dis_fsdi", 32'(o_fsdi), 32'd1);
    chk("dis_fsclk", 32'(o_fsclk), 32'd0);
    rd(4'h4, 32'h0000_0014);
    cnt = 0;
    repeat (20) begin
      @(negedge wb_clk);
      if (o_fsclk || !o_fsdi) cnt++;
    end
    chk("dis_idle", 32'(cnt), 32'd0);
    set_ctrl(3'b011);
    cnt = 0;
    while (!o_fsclk && cnt < 20) begin
      @(negedge wb_clk);
      if (!o_fsclk) cnt++;
    end
    chk("reen_low_half", 32'(cnt), 32'(CLK_DIV));
    wait_tx_done();
    rd(4'h4, 32'h0000_0016);

    // reset mid-frame: aborts at once, FIFO emptied
    send_tx(8'h81);
    send_tx(8'h92);
    repeat (3) wait_edge(1'b0);
    i_fscts = 1'b0;
    @(negedge wb_clk);
    wb_rst_n = 1'b0;
    #1;
    chk("rst_mid_fsdi", 32'(o_fsdi), 32'd1);
    chk("rst_mid_fsclk", 32'(o_fsclk), 32'd0);
    tx_q.delete();
    en_shadow   = 1'b0;
    chan_shadow = 1'b0;
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    @(negedge wb_clk);
    chk("post_rst_fsdi", 32'(o_fsdi), 32'd1);
    chk("post_rst_fsclk", 32'(o_fsclk), 32'd0);
    rd(4'h4, 32'h0000_0006);
    rd(4'h8, 32'h0000_0000);

    repeat (4) @(negedge wb_clk);
    if (rd_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL read_queue: %0d expected reads never completed", rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
